// File: rtl/pulse_gen_pkg.sv
// Shared pulse_gen definitions: packer states and host command codes.
// Imported by cmd_packer and by pulse_gen.
package pulse_gen_pkg;

  typedef enum logic [2:0] {
    S_B3       = 3'd0,
    S_B2       = 3'd1,
    S_B1       = 3'd2,
    S_B0       = 3'd3,
    S_DISPATCH = 3'd4
  } state_t;

  localparam logic [7:0] CMD_INSTR_MAX = 8'd6;
  localparam logic [7:0] CMD_PULSE_DEF = 8'd7;

  function automatic logic is_instr_cmd(
    input logic [7:0] c
  );
    return c <= CMD_INSTR_MAX;
  endfunction

endpackage

// File: rtl/cmd_packer.sv
// Packs host bytes into big-endian 32-bit words and routes them
// to the instruction or pulse FIFO by command byte.
module cmd_packer
  import pulse_gen_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000,
  parameter logic [7:0]  CMD_PULSE_DATA = CMD_PULSE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        instr_fifo_wr,
  output logic [31:0] instr_fifo_wdata,
  input  logic        instr_fifo_full,
  output logic        pulse_fifo_wr,
  output logic [31:0] pulse_fifo_wdata,
  input  logic        pulse_fifo_full,
  output logic [15:0] drop_count,
  output logic [7:0]  state_out
);

  state_t      state_q;
  state_t      state_d;
  logic        rdy_q;
  logic [31:0] word_q;
  logic [23:0] idle_q;

  logic        accept;
  logic        in_word;
  logic        timeout;
  logic [7:0]  cmd;
  logic        is_pulse;
  logic        is_instr;
  logic        do_instr;
  logic        do_pulse;
  logic        do_drop;

  // rdy_q keeps tready low until the first edge after reset release
  assign s_axis_tready = rdy_q && (state_q != S_DISPATCH);
  assign accept   = s_axis_tvalid && s_axis_tready;
  assign in_word  = (state_q == S_B2) || (state_q == S_B1)
                 || (state_q == S_B0);
  assign timeout  = in_word && !accept
                 && (idle_q == TIMEOUT_CYCLES - 24'd1);
  assign cmd      = word_q[31:24];
  assign is_pulse = (cmd == CMD_PULSE_DATA);
  assign is_instr = is_instr_cmd(cmd) && !is_pulse;
  assign state_out = {5'd0, state_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_B3;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    do_instr = 1'b0;
    do_pulse = 1'b0;
    do_drop  = 1'b0;
    unique case (state_q)
      S_B3: if (accept) state_d = S_B2;
      S_B2, S_B1, S_B0: begin
        if (accept) begin
          unique case (state_q)
            S_B2:    state_d = S_B1;
            S_B1:    state_d = S_B0;
            default: state_d = S_DISPATCH;
          endcase
        end else if (timeout) begin
          state_d = S_B3;
          do_drop = 1'b1;
        end
      end
      S_DISPATCH: begin
        unique case (1'b1)
          is_pulse: begin
            if (!pulse_fifo_full) begin
              do_pulse = 1'b1;
              state_d  = S_B3;
            end
          end
          is_instr: begin
            if (!instr_fifo_full) begin
              do_instr = 1'b1;
              state_d  = S_B3;
            end
          end
          default: begin
            do_drop = 1'b1;
            state_d = S_B3;
          end
        endcase
      end
      default: state_d = S_B3;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q            <= 1'b0;
      word_q           <= '0;
      idle_q           <= '0;
      instr_fifo_wr    <= 1'b0;
      instr_fifo_wdata <= '0;
      pulse_fifo_wr    <= 1'b0;
      pulse_fifo_wdata <= '0;
      drop_count       <= '0;
    end else begin
      rdy_q         <= 1'b1;
      instr_fifo_wr <= do_instr;
      pulse_fifo_wr <= do_pulse;
      if (accept) begin
        word_q <= {word_q[23:0], s_axis_tdata};
      end
      if (accept || !in_word || timeout) begin
        idle_q <= '0;
      end else begin
        idle_q <= idle_q + 24'd1;
      end
      if (do_instr) begin
        instr_fifo_wdata <= word_q;
      end
      if (do_pulse) begin
        pulse_fifo_wdata <= word_q;
      end
      if (do_drop && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cmd_packer.sv
// Directed bench for cmd_packer: dispatch timing, backpressure,
// drops, idle timeout, reset and back-to-back words.
module tb_cmd_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        instr_fifo_wr;
  logic [31:0] instr_fifo_wdata;
  logic        instr_fifo_full;
  logic        pulse_fifo_wr;
  logic [31:0] pulse_fifo_wdata;
  logic        pulse_fifo_full;
  logic [15:0] drop_count;
  logic [7:0]  state_out;

  int n_cmp  = 0;
  int n_bad  = 0;
  int stalls = 0;
  int both_hi = 0;
  logic [15:0] exp_drop = 16'd0;

  logic [31:0] instr_q[$];
  logic [31:0] pulse_q[$];

  cmd_packer #(
    .TIMEOUT_CYCLES(24'd16),
    .CMD_PULSE_DATA(8'd7)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .instr_fifo_wr    (instr_fifo_wr),
    .instr_fifo_wdata (instr_fifo_wdata),
    .instr_fifo_full  (instr_fifo_full),
    .pulse_fifo_wr    (pulse_fifo_wr),
    .pulse_fifo_wdata (pulse_fifo_wdata),
    .pulse_fifo_full  (pulse_fifo_full),
    .drop_count       (drop_count),
    .state_out        (state_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (instr_fifo_wr) instr_q.push_back(instr_fifo_wdata);
    if (pulse_fifo_wr) pulse_q.push_back(pulse_fifo_wdata);
    if (instr_fifo_wr && pulse_fifo_wr) both_hi++;
  end

  // Entered and left just after a negedge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 50) begin
      @(negedge clk);
      n++;
      stalls++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_byte: tready stuck low, got %0b want 1",
               s_axis_tready);
    end
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input bit keep);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
    if (!keep) s_axis_tvalid = 1'b0;
  endtask

  task automatic test_reset;
    rst             = 1'b0;
    s_axis_tvalid   = 1'b0;
    s_axis_tdata    = 8'h00;
    instr_fifo_full = 1'b0;
    pulse_fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({s_axis_tready, instr_fifo_wr, pulse_fifo_wr} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b want 000",
               {s_axis_tready, instr_fifo_wr, pulse_fifo_wr});
    end
    n_cmp++;
    if ({instr_fifo_wdata, pulse_fifo_wdata} !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_wdata: got %h want 0",
               {instr_fifo_wdata, pulse_fifo_wdata});
    end
    n_cmp++;
    if ({drop_count, state_out} !== 24'd0) begin
      n_bad++;
      $display("FAIL reset_drop_state: got %h want 0",
               {drop_count, state_out});
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (s_axis_tready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %b want 0", s_axis_tready);
    end
    @(negedge clk);
    n_cmp++;
    if (s_axis_tready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready_up: got %b want 1", s_axis_tready);
    end
  endtask

  task automatic test_instr;
    int ni;
    ni = instr_q.size();
    send_word(32'h01000503, 1'b0);
    n_cmp++;
    if ({instr_fifo_wr, state_out} !== {1'b0, 8'd4}) begin
      n_bad++;
      $display("FAIL instr_dispatch: got wr=%b st=%0d want wr=0 st=4",
               instr_fifo_wr, state_out);
    end
    @(negedge clk);
    n_cmp++;
    if ({instr_fifo_wr, pulse_fifo_wr, instr_fifo_wdata}
        !== {2'b10, 32'h01000503}) begin
      n_bad++;
      $display("FAIL instr_strobe: got wr=%b pw=%b d=%h want 1 0 01000503",
               instr_fifo_wr, pulse_fifo_wr, instr_fifo_wdata);
    end
    @(negedge clk);
    n_cmp++;
    if ({instr_fifo_wr, state_out} !== {1'b0, 8'd0}
        || instr_q.size() != ni + 1) begin
      n_bad++;
      $display("FAIL instr_single: got wr=%b st=%0d n=%0d want 0 0 %0d",
               instr_fifo_wr, state_out, instr_q.size(), ni + 1);
    end
  endtask

  task automatic test_pulse_backpressure;
    int np;
    int bad;
    np = pulse_q.size();
    bad = 0;
    pulse_fifo_full = 1'b1;
    send_word(32'h0700020A, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (s_axis_tready !== 1'b0 || pulse_fifo_wr !== 1'b0
          || state_out !== 8'd4) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad != 0 || pulse_q.size() != np) begin
      n_bad++;
      $display("FAIL pulse_stall: got %0d bad cycles, %0d writes want 0 0",
               bad, pulse_q.size() - np);
    end
    pulse_fifo_full = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({pulse_fifo_wr, instr_fifo_wr, pulse_fifo_wdata}
        !== {2'b10, 32'h0700020A}) begin
      n_bad++;
      $display("FAIL pulse_strobe: got pw=%b iw=%b d=%h want 1 0 0700020A",
               pulse_fifo_wr, instr_fifo_wr, pulse_fifo_wdata);
    end
    @(negedge clk);
    n_cmp++;
    if (pulse_fifo_wr !== 1'b0 || pulse_q.size() != np + 1) begin
      n_bad++;
      $display("FAIL pulse_single: got wr=%b n=%0d want 0 %0d",
               pulse_fifo_wr, pulse_q.size() - np, 1);
    end
  endtask

  task automatic test_drop;
    int ni;
    int np;
    ni = instr_q.size();
    np = pulse_q.size();
    send_word(32'h09112233, 1'b0);
    repeat (2) @(negedge clk);
    exp_drop = exp_drop + 16'd1;
    n_cmp++;
    if (drop_count !== exp_drop || instr_q.size() != ni
        || pulse_q.size() != np || state_out !== 8'd0) begin
      n_bad++;
      $display("FAIL drop_cmd: got drop=%0d st=%0d writes=%0d want %0d 0 0",
               drop_count, state_out,
               instr_q.size() - ni + pulse_q.size() - np, exp_drop);
    end
    send_word(32'h02000010, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (instr_q.size() != ni + 1 || instr_q[$] !== 32'h02000010) begin
      n_bad++;
      $display("FAIL drop_next: got n=%0d d=%h want 1 02000010",
               instr_q.size() - ni, instr_fifo_wdata);
    end
  endtask

  task automatic test_timeout;
    int ni;
    send_byte(8'h01);
    send_byte(8'h00);
    s_axis_tvalid = 1'b0;
    repeat (15) @(negedge clk);
    n_cmp++;
    if (drop_count !== exp_drop || state_out !== 8'd2) begin
      n_bad++;
      $display("FAIL timeout_early: got drop=%0d st=%0d want %0d 2",
               drop_count, state_out, exp_drop);
    end
    @(negedge clk);
    exp_drop = exp_drop + 16'd1;
    n_cmp++;
    if (drop_count !== exp_drop || state_out !== 8'd0) begin
      n_bad++;
      $display("FAIL timeout_fire: got drop=%0d st=%0d want %0d 0",
               drop_count, state_out, exp_drop);
    end
    ni = instr_q.size();
    send_word(32'h06000005, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (instr_q.size() != ni + 1 || instr_q[$] !== 32'h06000005) begin
      n_bad++;
      $display("FAIL timeout_next: got n=%0d d=%h want 1 06000005",
               instr_q.size() - ni, instr_fifo_wdata);
    end
  endtask

  task automatic test_reset_mid;
    int ni;
    send_byte(8'h05);
    send_byte(8'h55);
    s_axis_tvalid = 1'b0;
    rst = 1'b0;
    #1;
    exp_drop = 16'd0;
    n_cmp++;
    if ({s_axis_tready, instr_fifo_wr, pulse_fifo_wr, drop_count,
         state_out, instr_fifo_wdata, pulse_fifo_wdata} !== '0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got rdy=%b drop=%0d st=%0d want 0",
               s_axis_tready, drop_count, state_out);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (s_axis_tready !== 1'b1 || drop_count !== 16'd0) begin
      n_bad++;
      $display("FAIL rstmid_release: got rdy=%b drop=%0d want 1 0",
               s_axis_tready, drop_count);
    end
    ni = instr_q.size();
    send_word(32'h03AABBCC, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (instr_q.size() != ni + 1 || instr_q[$] !== 32'h03AABBCC
        || drop_count !== 16'd0) begin
      n_bad++;
      $display("FAIL rstmid_fresh: got n=%0d d=%h drop=%0d want 1 03AABBCC 0",
               instr_q.size() - ni, instr_fifo_wdata, drop_count);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_i[$];
    logic [31:0] exp_p[$];
    logic [31:0] w;
    int bad;
    instr_q.delete();
    pulse_q.delete();
    stalls = 0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      w = $urandom;
      w[31:24] = 8'($urandom_range(0, 7));
      if (w[31:24] == 8'd7) exp_p.push_back(w);
      else exp_i.push_back(w);
      send_word(w, 1'b1);
    end
    s_axis_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (instr_q.size() != exp_i.size() || pulse_q.size() != exp_p.size()) begin
      n_bad++;
      $display("FAIL b2b_count: got i=%0d p=%0d want i=%0d p=%0d",
               instr_q.size(), pulse_q.size(), exp_i.size(), exp_p.size());
    end else begin
      for (int i = 0; i < exp_i.size(); i++)
        if (instr_q[i] !== exp_i[i]) bad++;
      for (int i = 0; i < exp_p.size(); i++)
        if (pulse_q[i] !== exp_p[i]) bad++;
      n_cmp++;
      if (bad != 0) begin
        n_bad++;
        $display("FAIL b2b_order: got %0d wrong words want 0", bad);
      end
    end
    n_cmp++;
    if (stalls != 99) begin
      n_bad++;
      $display("FAIL b2b_gaps: got %0d stall cycles want 99", stalls);
    end
    n_cmp++;
    if (both_hi != 0 || drop_count !== 16'd0) begin
      n_bad++;
      $display("FAIL b2b_strobes: got both=%0d drop=%0d want 0 0",
               both_hi, drop_count);
    end
  endtask

  initial begin
    test_reset();
    test_instr();
    test_pulse_backpressure();
    test_drop();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmd_packer.md
CMD_PACKER -- requirements
Module: cmd_packer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd1000000: idle cycles allowed between bytes of one word.
REQ-002 SHALL have parameter CMD_PULSE_DATA, default 8'd7: command byte that routes a word to the pulse FIFO.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_axis_tdata  input  8  host byte stream.
REQ-006 SHALL have port s_axis_tvalid  input  1  byte valid.
REQ-007 SHALL have port s_axis_tready  output  1  byte accepted when tvalid and tready are both high.
REQ-008 SHALL have ports instr_fifo_wr  output  1, instr_fifo_wdata  output  32, instr_fifo_full  input  1: instruction FIFO write side.
REQ-009 SHALL have ports pulse_fifo_wr  output  1, pulse_fifo_wdata  output  32, pulse_fifo_full  input  1: pulse FIFO write side.
REQ-010 SHALL have port drop_count  output  16  count of discarded words, saturating.
REQ-011 SHALL have port state_out  output  8  current state encoding, for debug.

Function
REQ-012 SHALL assemble words big-endian: 1st byte to [31:24] (command), 2nd to [23:16], 3rd to [15:8], 4th to [7:0].
REQ-013 SHALL implement states S_B3=0, S_B2=1, S_B1=2, S_B0=3, S_DISPATCH=4; an accepted byte advances S_B3->S_B2->S_B1->S_B0->S_DISPATCH.
REQ-014 SHALL drive s_axis_tready=1 in S_B3..S_B0 and 0 in S_DISPATCH.
REQ-015 SHALL, in S_DISPATCH with command in 0..6 and instr_fifo_full=0, register instr_fifo_wr=1 for exactly one cycle with the word on instr_fifo_wdata, then go to S_B3.
REQ-016 SHALL, in S_DISPATCH with command==CMD_PULSE_DATA and pulse_fifo_full=0, register pulse_fifo_wr=1 for exactly one cycle with the word on pulse_fifo_wdata, then go to S_B3.
REQ-017 SHALL stay in S_DISPATCH, with no write and tready=0, while the target FIFO's full is 1; no word SHALL be lost to backpressure.
REQ-018 SHALL discard any other command value in S_DISPATCH within one cycle, with no write; drop_count SHALL increment and the state SHALL go to S_B3.
REQ-019 SHALL assert the write strobe in the cycle after the S_DISPATCH decision edge, giving 2 cycles from acceptance of the 4th byte to the strobe when not full.
REQ-020 SHALL hold wdata stable while the strobe is high; wr strobes SHALL never be asserted together.
REQ-021 SHALL use a 24-bit idle counter, cleared on every accepted byte and counting only in S_B2, S_B1 and S_B0.
REQ-022 SHALL, on reaching TIMEOUT_CYCLES-1 with no byte accepted in that cycle, discard the partial word, increment drop_count and go to S_B3.
REQ-023 SHALL give an accepted byte priority over the timeout when both occur in the same cycle.
REQ-024 SHALL saturate drop_count at 16'hFFFF.
REQ-025 SHALL start back-to-back words with no gap beyond the single S_DISPATCH cycle.

Reset
REQ-026 SHALL, on rst low, asynchronously set: state=S_B3, s_axis_tready=0, instr_fifo_wr=0, pulse_fifo_wr=0, both wdata=0, drop_count=0, idle counter=0, word shift register=0.
REQ-027 SHALL raise s_axis_tready the first cycle after rst deasserts.
REQ-028 SHALL, on reset mid-word or mid-dispatch, lose the partial or pending word silently, without counting it in drop_count.

Structure
REQ-029 SHALL take command codes 0..6, CMD_PULSE_DATA and the state encodings from shared package pulse_gen_pkg, which pulse_gen also uses.
REQ-030 SHALL be a single module with no sub-module; the FIFOs stay external.

Verification
REQ-031 SHALL cover: bytes 01 00 05 03 -> one instr_fifo_wr, wdata 32'h01000503, 2 cycles after the 4th byte.
REQ-032 SHALL cover: bytes 07 00 02 0A with pulse_fifo_full=1 for 10 cycles -> tready=0 throughout, then one pulse_fifo_wr, wdata 32'h0700020A.
REQ-033 SHALL cover: bytes 09 11 22 33 -> no write strobe, drop_count=1, next word 02 00 00 10 -> instr_fifo_wr, wdata 32'h02000010.
REQ-034 SHALL cover: TIMEOUT_CYCLES=16, bytes 01 00 then 16 idle cycles -> drop_count=1, state_out=0; then 06 00 00 05 -> instr_fifo_wr, wdata 32'h06000005.
REQ-035 SHALL cover: rst low after 2 bytes, then release -> all outputs 0 during reset, tready=1 one cycle after release, drop_count=0, next 4 bytes form a fresh word.
REQ-036 SHALL cover: 100 back-to-back random valid words with tvalid held high -> one write per word, in order, to the correct FIFO.
